// File: rtl/lcd_timing_pkg.sv
// Shared raster-timing definitions for the display path: default 640x480@60
// geometry, the RGB565 pixel type and the line/frame total helper.
package lcd_timing_pkg;

   localparam int unsigned CNT_W   = 11;
   localparam int unsigned RGB_W   = 16;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   localparam int unsigned DEF_H_SYNC  = 96;
   localparam int unsigned DEF_H_BACK  = 48;
   localparam int unsigned DEF_H_DISP  = 640;
   localparam int unsigned DEF_H_FRONT = 16;
   localparam int unsigned DEF_V_SYNC  = 2;
   localparam int unsigned DEF_V_BACK  = 33;
   localparam int unsigned DEF_V_DISP  = 480;
   localparam int unsigned DEF_V_FRONT = 10;

   // RGB565 pixel as produced by every pixel generator
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;

   // Per-pixel timing flags carried alongside the pixel through the pipeline
   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic fs;
   } tim_flags_t;

   localparam int unsigned FLAGS_W = $bits(tim_flags_t);

   // Total clocks per line (or lines per frame) from the four segment widths
   function automatic int unsigned calc_total(input int unsigned sync_w,
                                              input int unsigned back_w,
                                              input int unsigned disp_w,
                                              input int unsigned front_w);
      return sync_w + back_w + disp_w + front_w;
   endfunction

endpackage

// File: rtl/lcd_timing_gen_sig_delay.sv
// Fixed-depth shift delay with synchronous reset to a programmable value.
module sig_delay #(
   parameter int unsigned       WIDTH   = 1,
   parameter int unsigned       DEPTH   = 1,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sig_i,
   output logic [WIDTH-1:0] sig_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   // Shift chain; every stage returns to RST_VAL while rst is high
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
         end
      end else begin
         stage_q[0] <= sig_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign sig_o = stage_q[DEPTH-1];

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator: sweeps h/v counters, requests pixels by active-area
// coordinate, and emits sync/de/rgb aligned to the returned pixel.
module lcd_timing_gen
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BACK   = DEF_H_BACK,
   parameter int unsigned H_DISP   = DEF_H_DISP,
   parameter int unsigned H_FRONT  = DEF_H_FRONT,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BACK   = DEF_V_BACK,
   parameter int unsigned V_DISP   = DEF_V_DISP,
   parameter int unsigned V_FRONT  = DEF_V_FRONT,
   parameter logic        SYNC_POL = 1'b0,
   parameter int unsigned PIX_LAT  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  rgb565_t          pixel_data,
   output logic [CNT_W-1:0] pixel_xpos,
   output logic [CNT_W-1:0] pixel_ypos,
   output logic             lcd_hs,
   output logic             lcd_vs,
   output logic             lcd_de,
   output rgb565_t          lcd_rgb,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = calc_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
   localparam int unsigned V_TOTAL = calc_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

   // Geometry must fit the 11-bit counters and the latency must be supported
   if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_geom
      $error("lcd_timing_gen: H_TOTAL/V_TOTAL must be 1..%0d", CNT_MAX);
   end
   if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
      $error("lcd_timing_gen: PIX_LAT must be 1..4");
   end

   localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BACK + H_DISP);
   localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BACK + V_DISP);
   localparam int unsigned      DLY      = PIX_LAT + 1;

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic [CNT_W-1:0] xpos_q, xpos_d;
   logic [CNT_W-1:0] ypos_q, ypos_d;
   logic             act_c;
   tim_flags_t       flags_c;
   tim_flags_t       flags_dly;
   logic             lcd_hs_q, lcd_vs_q, lcd_de_q, frame_start_q;
   rgb565_t          lcd_rgb_q;

   // Counter advance: h wraps every line, v steps on each h wrap
   always_comb begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_MAX) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + CNT_W'(1);
      end
   end

   // Raster position registers
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Decode of the current counter position into timing flags and coordinates
   always_comb begin
      act_c      = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E) &&
                   (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
      flags_c.hs = (h_cnt_q < H_SYNC_C);
      flags_c.vs = (v_cnt_q < V_SYNC_C);
      flags_c.de = act_c;
      flags_c.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
      xpos_d     = act_c ? h_cnt_q - H_ACT_S : '0;
      ypos_d     = act_c ? v_cnt_q - V_ACT_S : '0;
   end

   // Coordinate request to the pixel generators
   always_ff @(posedge clk) begin
      if (rst) begin
         xpos_q <= '0;
         ypos_q <= '0;
      end else begin
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
      end
   end

   // Flags wait out the coordinate register plus the generator latency
   sig_delay #(
      .WIDTH   (FLAGS_W),
      .DEPTH   (DLY),
      .RST_VAL ('0)
   ) u_flag_dly (
      .clk   (clk),
      .rst   (rst),
      .sig_i (flags_c),
      .sig_o (flags_dly)
   );

   // Pin stage: sync polarity applied, pixel gated to the active area
   always_ff @(posedge clk) begin
      if (rst) begin
         lcd_hs_q      <= ~SYNC_POL;
         lcd_vs_q      <= ~SYNC_POL;
         lcd_de_q      <= 1'b0;
         lcd_rgb_q     <= '0;
         frame_start_q <= 1'b0;
      end else begin
         lcd_hs_q      <= flags_dly.hs ? SYNC_POL : ~SYNC_POL;
         lcd_vs_q      <= flags_dly.vs ? SYNC_POL : ~SYNC_POL;
         lcd_de_q      <= flags_dly.de;
         lcd_rgb_q     <= flags_dly.de ? pixel_data : '0;
         frame_start_q <= flags_dly.fs;
      end
   end

   assign pixel_xpos  = xpos_q;
   assign pixel_ypos  = ypos_q;
   assign lcd_hs      = lcd_hs_q;
   assign lcd_vs      = lcd_vs_q;
   assign lcd_de      = lcd_de_q;
   assign lcd_rgb     = lcd_rgb_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a reduced 12x8 raster: one instance at
// PIX_LAT=1/SYNC_POL=0 and one at PIX_LAT=3/SYNC_POL=1, each fed by a bench
// pixel generator that returns its own coordinate.
module tb_lcd_timing_gen;

   localparam int HS = 3, HB = 2, HD = 6, HF = 1;
   localparam int VS = 1, VB = 2, VD = 4, VF = 1;
   localparam int HT = HS + HB + HD + HF;   // 12
   localparam int VT = VS + VB + VD + VF;   // 8
   localparam int HA0 = HS + HB;
   localparam int VA0 = VS + VB;

   typedef struct packed {
      logic        fs;
      logic        de;
      logic        vs;
      logic        hs;
      logic [15:0] rgb;
      logic [10:0] x;
      logic [10:0] y;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        force_ff = 1'b0;
   logic [15:0] pd_a, pd_b, pb1, pb2;
   logic [10:0] xpos_a, ypos_a, xpos_b, ypos_b;
   logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
   logic [15:0] rgb_a, rgb_b;

   int checks = 0;
   int errors = 0;
   int t = 0;

   always #5 clk = ~clk;

   lcd_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .SYNC_POL(1'b0), .PIX_LAT(1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .pixel_data(pd_a),
      .pixel_xpos(xpos_a), .pixel_ypos(ypos_a),
      .lcd_hs(hs_a), .lcd_vs(vs_a), .lcd_de(de_a),
      .lcd_rgb(rgb_a), .frame_start(fs_a)
   );

   lcd_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .SYNC_POL(1'b1), .PIX_LAT(3)
   ) u_dut_b (
      .clk(clk), .rst(rst), .pixel_data(pd_b),
      .pixel_xpos(xpos_b), .pixel_ypos(ypos_b),
      .lcd_hs(hs_b), .lcd_vs(vs_b), .lcd_de(de_b),
      .lcd_rgb(rgb_b), .frame_start(fs_b)
   );

   // Bench pixel generators: 1-deep for A, 3-deep for B
   always @(posedge clk) begin
      pd_a <= force_ff ? 16'hFFFF : {ypos_a[4:0], xpos_a};
      pb1  <= {ypos_b[4:0], xpos_b};
      pb2  <= pb1;
      pd_b <= pb2;
   end

   // Expected pin state for raster cycle n (n < 0 means pipeline still clear)
   function automatic exp_t model(input int n, input logic pol, input bit ff);
      exp_t e;
      int   h, v;
      bit   act;
      e.fs = 1'b0; e.de = 1'b0; e.vs = ~pol; e.hs = ~pol;
      e.rgb = 16'h0; e.x = 11'd0; e.y = 11'd0;
      if (n >= 0) begin
         h    = n % HT;
         v    = (n / HT) % VT;
         act  = (h >= HA0) && (h < HA0 + HD) && (v >= VA0) && (v < VA0 + VD);
         e.hs = (h < HS) ? pol : ~pol;
         e.vs = (v < VS) ? pol : ~pol;
         e.de = act;
         e.fs = (h == 0) && (v == 0);
         if (act) begin
            e.x   = 11'(h - HA0);
            e.y   = 11'(v - VA0);
            e.rgb = ff ? 16'hFFFF : {e.y[4:0], e.x};
         end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_hs_a"}, hs_a, 1'b1);
      chk({tag, "_vs_a"}, vs_a, 1'b1);
      chk({tag, "_de_a"}, de_a, 1'b0);
      chk({tag, "_rgb_a"}, rgb_a, 16'h0);
      chk({tag, "_fs_a"}, fs_a, 1'b0);
      chk({tag, "_x_a"}, xpos_a, 11'd0);
      chk({tag, "_y_a"}, ypos_a, 11'd0);
      chk({tag, "_hs_b"}, hs_b, 1'b0);
      chk({tag, "_vs_b"}, vs_b, 1'b0);
      chk({tag, "_de_b"}, de_b, 1'b0);
      chk({tag, "_rgb_b"}, rgb_b, 16'h0);
      chk({tag, "_fs_b"}, fs_b, 1'b0);
   endtask

   // Run from release, checking every cycle plus hand-computed landmarks
   task automatic run(input int cycles, input bit ff);
      exp_t ea, eb, pa, pb;
      int   last_fs = -1;
      int   de_cnt = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         t++;
         ea = model(t - 3, 1'b0, ff);
         eb = model(t - 5, 1'b1, 1'b0);
         pa = model(t - 1, 1'b0, ff);
         chk("a_hs", hs_a, ea.hs);
         chk("a_vs", vs_a, ea.vs);
         chk("a_de", de_a, ea.de);
         chk("a_fs", fs_a, ea.fs);
         chk("a_rgb", rgb_a, ea.rgb);
         chk("a_x", xpos_a, pa.x);
         chk("a_y", ypos_a, pa.y);
         chk("b_hs", hs_b, eb.hs);
         chk("b_vs", vs_b, eb.vs);
         chk("b_de", de_b, eb.de);
         chk("b_fs", fs_b, eb.fs);
         chk("b_rgb", rgb_b, eb.rgb);
         pb = model(t - 1, 1'b1, 1'b0);
         chk("b_x", xpos_b, pb.x);
         if (t == 3) begin
            chk("a_first_fs", fs_a, 1'b1);
            chk("a_first_hs", hs_a, 1'b0);
            chk("b_no_fs_yet", fs_b, 1'b0);
         end
         if (t == 5) begin
            chk("b_first_fs", fs_b, 1'b1);
            chk("b_first_hs", hs_b, 1'b1);
            chk("a_hs_last_low", hs_a, 1'b0);
         end
         if (t == 6) chk("a_hs_release", hs_a, 1'b1);
         if (!ff && t == 43) chk("a_pre_active_de", de_a, 1'b0);
         if (!ff && t == 44) begin
            chk("a_first_pix_de", de_a, 1'b1);
            chk("a_first_pix_rgb", rgb_a, 16'h0000);
         end
         if (!ff && t == 85) chk("a_last_pix_rgb", rgb_a, 16'h1805);
         if (!ff && t == 86) chk("a_after_last_de", de_a, 1'b0);
         if (fs_a === 1'b1) begin
            if (last_fs >= 0) begin
               chk("a_frame_len", t - last_fs, HT * VT);
               chk("a_de_per_frame", de_cnt, HD * VD);
            end
            last_fs = t;
            de_cnt  = 0;
         end
         if (de_a === 1'b1) de_cnt++;
      end
   endtask

   initial begin
      // Reset hold: outputs at reset values throughout
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk_reset_vals("hold");
      end
      rst = 1'b0;
      t   = 0;
      run(250, 1'b0);

      // Single-cycle reset in the middle of an active line
      rst = 1'b1;
      @(negedge clk);
      chk("mid_de_before", de_a, 1'b0);
      rst = 1'b0;
      chk_reset_vals("midrst");
      t = 0;
      run(120, 1'b0);

      // Constant white generator: rgb only inside the active window
      rst = 1'b1;
      force_ff = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("ffrst");
      rst = 1'b0;
      t   = 0;
      run(200, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Raster timing generator and pixel-alignment stage for the snake game display path. It sweeps the horizontal and vertical counters, issues `pixel_xpos`/`pixel_ypos` to the screen pixel generators (start screen, game field, game-over) and registers their 16-bit RGB565 answer. It then emits sync, data-enable and RGB to the panel/VGA pins, all aligned to the same pixel. It sits directly upstream of every pixel generator and directly drives the display pins.

## Interface
Parameters:
- `H_SYNC` 96 — hsync pulse width, pixel clocks
- `H_BACK` 48 — horizontal back porch
- `H_DISP` 640 — active pixels per line
- `H_FRONT` 16 — horizontal front porch
- `V_SYNC` 2, `V_BACK` 33, `V_DISP` 480, `V_FRONT` 10 — vertical equivalents, in lines
- `SYNC_POL` 0 — active level of `lcd_hs`/`lcd_vs`
- `PIX_LAT` 1 — clock cycles from `pixel_xpos`/`pixel_ypos` change to valid `pixel_data`; legal 1..4

Ports:
- `clk` input 1 — pixel clock
- `rst` input 1 — synchronous, active-high reset
- `pixel_data` input 16 — RGB565 from the selected pixel generator
- `pixel_xpos` output 11 — active-area column being requested
- `pixel_ypos` output 11 — active-area row being requested
- `lcd_hs` output 1 — horizontal sync
- `lcd_vs` output 1 — vertical sync
- `lcd_de` output 1 — data enable, high during active pixels
- `lcd_rgb` output 16 — RGB565 to pins; 0 outside active area
- `frame_start` output 1 — one-cycle pulse on first pixel clock of each frame

## Operation
- `h_cnt` 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), increments every cycle, wraps to 0; `v_cnt` 0..V_TOTAL-1 (525) increments when `h_cnt` wraps, wraps to 0 when both at max.
- Decode at counter cycle n: hs_act = h_cnt < H_SYNC; vs_act = v_cnt < V_SYNC; act = h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP); fs = (h_cnt==0 && v_cnt==0).
- `pixel_xpos`/`pixel_ypos` registered from decode: act ? h_cnt-(H_SYNC+H_BACK) : 0 and act ? v_cnt-(V_SYNC+V_BACK) : 0. Both 0 when not active.
- hs_act, vs_act, act, fs delayed so they leave the block in the same cycle as the matching `lcd_rgb`.
- `lcd_rgb` registered: delayed act ? `pixel_data` : 16'h0000.
- `lcd_hs` = hs_act_delayed ? SYNC_POL : ~SYNC_POL; same for `lcd_vs`.
- Counter arithmetic is 11-bit unsigned. Parameter sums must fit (H_TOTAL, V_TOTAL ≤ 2047); elaboration-time check fails otherwise.

## Timing
- Latency: counter cycle n → pixel_xpos/ypos valid at n+1 → pixel_data valid at n+1+PIX_LAT → lcd_rgb, lcd_hs, lcd_vs, lcd_de, frame_start at n+2+PIX_LAT (n+3 default).
- Reset: while `rst` high, counters 0, every pipeline stage cleared. Outputs: `lcd_hs`=`lcd_vs`=~SYNC_POL, `lcd_de`=0, `lcd_rgb`=0, `pixel_xpos`=`pixel_ypos`=0, `frame_start`=0.
- First cycle after `rst` falls: `h_cnt`=0; first `frame_start` and first active `lcd_hs` appear 2+PIX_LAT cycles later.
- Reset mid-frame: frame abandoned immediately; outputs return to reset values next edge; restart from (0,0). No partial-line completion.
- Line wrap (h_cnt 799→0) and frame wrap (799,524 → 0,0) occur without dead cycles. `lcd_de` low for exactly H_TOTAL−H_DISP = 160 cycles between lines.
- Vsync edges coincide with an hsync leading edge.
- `pixel_data` sampled only when the delayed act is high; other values ignored.

## Structure
- Shared package `lcd_timing_pkg`: default 640x480@60 constants, RGB565 type, `H_TOTAL`/`V_TOTAL` computation function; pixel generators import the same RGB type.
- One sub-module `sig_delay` (parameterised width and depth, synchronous reset to a parameter value) delays hs/vs/de/fs; instantiated for the `PIX_LAT+1` stages.

## Test plan
- Reset held 10 cycles, then released → outputs at reset values during hold; `frame_start` pulses exactly at cycle 3 after release; `lcd_hs` low (SYNC_POL=0) cycles 3..98.
- Full frame → exactly 800×525 = 420000 cycles between `frame_start` pulses; `lcd_de` high 640×480 = 307200 cycles per frame.
- Bench returns pixel_data = {pixel_ypos[4:0], pixel_xpos[10:0]} with 1-cycle register → every `lcd_de` cycle `lcd_rgb` equals the coordinate of its own pixel; first active pixel is (0,0), last is (639,479).
- Pixel_data forced 16'hFFFF constantly → `lcd_rgb` 16'hFFFF only while `lcd_de`=1, 0 otherwise; `pixel_xpos`=0 during blanking.
- `rst` asserted for 1 cycle at h_cnt=400, line 300 → next edge all outputs at reset values; next `frame_start` 3 cycles after release.
- PIX_LAT=3, SYNC_POL=1 build → outputs appear at n+5, sync pulses high; alignment check from scenario 3 still passes with a 3-deep bench pipeline.
